// File: rtl/pipe_stage_chain_if.sv
// Handshake bundle for pipe_stage_chain: upstream valid/ready, downstream valid/ready, flush and occupancy.
// Transfer on either side happens on a rising clk edge when valid and ready are both high in that cycle.
interface pipe_stage_chain_if #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 8,
    parameter int STAGES = 1
);
    localparam int OCC_W = $clog2(STAGES + 2);

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic              out_ready;
    logic              flush;
    logic [OCC_W-1:0]  occ;

    modport master (
        output in_valid, in_data, in_ctrl, out_ready, flush,
        input  in_ready, out_valid, out_data, out_ctrl, occ
    );

    modport slave (
        input  in_valid, in_data, in_ctrl, out_ready, flush,
        output in_ready, out_valid, out_data, out_ctrl, occ
    );
endinterface

// File: rtl/pipe_stage_chain.sv
// Elastic pipeline-register chain with per-slot valid, backpressure and flush.
// Define PIPE_STAGE_CHAIN_SKID_EN to add a one-entry skid buffer that registers in_ready.
module pipe_stage_chain #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 8,
    parameter int STAGES = 1,
    localparam int OCC_W = $clog2(STAGES + 2)
) (
    input logic               clk,
    input logic               rst,
    pipe_stage_chain_if.slave bus
);
    localparam int LAST = STAGES - 1;

    logic [STAGES-1:0] valid;
    logic [DATA_W-1:0] data [STAGES];
    logic [CTRL_W-1:0] ctrl [STAGES];
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] load;
    logic [DATA_W-1:0] src_data [STAGES];
    logic [CTRL_W-1:0] src_ctrl [STAGES];
    logic              can0;
    logic              transfer;
    logic              consume;
    logic              load0;
    logic [DATA_W-1:0] load0_data;
    logic [CTRL_W-1:0] load0_ctrl;
    logic [OCC_W-1:0]  occ_q;
    logic [OCC_W-1:0]  held;

    // A valid slot moves whenever any slot downstream of it is empty or the tail is consumed,
    // which collapses bubbles without a combinational loop through adv.
    always_comb begin
        logic open_path;
        open_path = bus.out_ready;
        adv = '0;
        for (int k = LAST; k >= 0; k--) begin
            adv[k] = valid[k] & open_path;
            open_path = open_path | ~valid[k];
        end
    end

    assign can0     = ~valid[0] | adv[0];
    assign consume  = valid[LAST] & bus.out_ready;
    assign transfer = bus.in_valid & bus.in_ready;

`ifdef PIPE_STAGE_CHAIN_SKID_EN
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;

    // Skid content is older than anything on the input, so it always wins slot 0.
    assign bus.in_ready = ~skid_valid & ~bus.flush;
    assign load0        = can0 & (skid_valid | transfer);
    assign load0_data   = skid_valid ? skid_data : bus.in_data;
    assign load0_ctrl   = skid_valid ? skid_ctrl : bus.in_ctrl;
    assign held         = OCC_W'($countones(valid)) + OCC_W'(skid_valid);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_ctrl  <= '0;
        end else if (bus.flush) begin
            skid_valid <= 1'b0;
            skid_ctrl  <= '0;
        end else if (skid_valid && can0) begin
            skid_valid <= 1'b0;
            skid_ctrl  <= '0;
        end else if (transfer && !can0) begin
            skid_valid <= 1'b1;
            skid_data  <= bus.in_data;
            skid_ctrl  <= bus.in_ctrl;
        end
    end
`else
    assign bus.in_ready = can0 & ~bus.flush;
    assign load0        = transfer;
    assign load0_data   = bus.in_data;
    assign load0_ctrl   = bus.in_ctrl;
    assign held         = OCC_W'($countones(valid));
`endif

    always_comb begin
        load = '0;
        for (int k = 0; k < STAGES; k++) begin
            src_data[k] = '0;
            src_ctrl[k] = '0;
        end
        load[0]     = load0;
        src_data[0] = load0_data;
        src_ctrl[0] = load0_ctrl;
        for (int k = 1; k < STAGES; k++) begin
            load[k]     = adv[k-1];
            src_data[k] = data[k-1];
            src_ctrl[k] = ctrl[k-1];
        end
    end

    // Control fields are cleared whenever a slot goes empty so a killed entry reads as a NOP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
            for (int k = 0; k < STAGES; k++) begin
                data[k] <= '0;
                ctrl[k] <= '0;
            end
        end else if (bus.flush) begin
            valid <= '0;
            for (int k = 0; k < STAGES; k++) begin
                ctrl[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (load[k]) begin
                    valid[k] <= 1'b1;
                    data[k]  <= src_data[k];
                    ctrl[k]  <= src_ctrl[k];
                end else if (adv[k]) begin
                    valid[k] <= 1'b0;
                    ctrl[k]  <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_q <= '0;
        end else if (bus.flush) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_q + OCC_W'(transfer) - OCC_W'(consume);
        end
    end

    assign bus.out_valid = valid[LAST];
    assign bus.out_data  = data[LAST];
    assign bus.out_ctrl  = valid[LAST] ? ctrl[LAST] : '0;
    assign bus.occ       = occ_q;

    a_occ_matches_valid: assert property (@(posedge clk) disable iff (!rst) occ_q == held);
endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed and randomized checks of pipe_stage_chain (3-slot and 4-slot instances).
// Expectations adapt to PIPE_STAGE_CHAIN_SKID_EN through the CAP constant.
module tb_pipe_stage_chain;
`ifdef PIPE_STAGE_CHAIN_SKID_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 3;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    pipe_stage_chain_if #(.DATA_W(16), .CTRL_W(4), .STAGES(3)) b3 ();
    pipe_stage_chain_if #(.DATA_W(16), .CTRL_W(4), .STAGES(4)) b4 ();

    pipe_stage_chain #(.DATA_W(16), .CTRL_W(4), .STAGES(3)) dut3 (
        .clk(clk), .rst(rst), .bus(b3.slave)
    );
    pipe_stage_chain #(.DATA_W(16), .CTRL_W(4), .STAGES(4)) dut4 (
        .clk(clk), .rst(rst), .bus(b4.slave)
    );

    function automatic logic [3:0] ctrl_of(input logic [15:0] d);
        return d[3:0] ^ 4'hA;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive3(input logic v, input logic [15:0] d, input logic r, input logic f);
        b3.in_valid  = v;
        b3.in_data   = d;
        b3.in_ctrl   = ctrl_of(d);
        b3.out_ready = r;
        b3.flush     = f;
    endtask

    task automatic drive4(input logic v, input logic [15:0] d, input logic r, input logic f);
        b4.in_valid  = v;
        b4.in_data   = d;
        b4.in_ctrl   = ctrl_of(d);
        b4.out_ready = r;
        b4.flush     = f;
    endtask

    task automatic test_reset();
        #3;
        total++; if (b3.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", b3.out_valid); end
        total++; if (b3.out_ctrl !== 4'h0) begin bad++; $display("FAIL rst_out_ctrl got=%h want=0", b3.out_ctrl); end
        total++; if (b3.out_data !== 16'h0) begin bad++; $display("FAIL rst_out_data got=%h want=0", b3.out_data); end
        total++; if (b3.occ !== 3'd0) begin bad++; $display("FAIL rst_occ got=%0d want=0", b3.occ); end
        tick();
        rst = 1'b1;
        #1;
        total++; if (b3.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", b3.in_ready); end
        tick();
        for (int i = 0; i < 3; i++) begin
            drive3(1'b1, 16'h50 + 16'(i), 1'b0, 1'b0);
            tick();
        end
        drive3(1'b0, 16'h0, 1'b0, 1'b0);
        #1;
        total++; if (b3.occ !== 3'd3) begin bad++; $display("FAIL mid_occ got=%0d want=3", b3.occ); end
        total++; if (b3.out_valid !== 1'b1) begin bad++; $display("FAIL mid_out_valid got=%b want=1", b3.out_valid); end
        rst = 1'b0;
        #1;
        total++; if (b3.out_valid !== 1'b0) begin bad++; $display("FAIL async_out_valid got=%b want=0", b3.out_valid); end
        total++; if (b3.out_ctrl !== 4'h0) begin bad++; $display("FAIL async_out_ctrl got=%h want=0", b3.out_ctrl); end
        total++; if (b3.occ !== 3'd0) begin bad++; $display("FAIL async_occ got=%0d want=0", b3.occ); end
        tick();
        rst = 1'b1;
        #1;
        total++; if (b3.in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready got=%b want=1", b3.in_ready); end
        tick();
    endtask

    task automatic test_streaming();
        for (int n = 0; n < 20; n++) begin
            drive3(n < 16, 16'h10 + 16'(n), 1'b1, 1'b0);
            #1;
            if (n < 16) begin
                total++; if (b3.in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready n=%0d got=%b want=1", n, b3.in_ready); end
            end
            total++;
            if (b3.out_valid !== (n >= 3 && n <= 18)) begin
                bad++; $display("FAIL stream_out_valid n=%0d got=%b want=%b", n, b3.out_valid, (n >= 3 && n <= 18));
            end
            if (n >= 3 && n <= 18) begin
                total++;
                if (b3.out_data !== 16'h10 + 16'(n - 3)) begin
                    bad++; $display("FAIL stream_out_data n=%0d got=%h want=%h", n, b3.out_data, 16'h10 + 16'(n - 3));
                end
                total++;
                if (b3.out_ctrl !== ctrl_of(16'h10 + 16'(n - 3))) begin
                    bad++; $display("FAIL stream_out_ctrl n=%0d got=%h want=%h", n, b3.out_ctrl, ctrl_of(16'h10 + 16'(n - 3)));
                end
            end
            if (n >= 3 && n <= 16) begin
                total++; if (b3.occ !== 3'd3) begin bad++; $display("FAIL stream_occ n=%0d got=%0d want=3", n, b3.occ); end
            end
            tick();
        end
        drive3(1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic test_stall();
        int sent;
        int rcv;
        sent = 0;
        rcv = 0;
        for (int i = 0; i < 8; i++) begin
            drive3(1'b1, 16'h20 + 16'(sent), 1'b0, 1'b0);
            #1;
            total++;
            if (b3.in_ready !== (i < CAP)) begin
                bad++; $display("FAIL stall_in_ready i=%0d got=%b want=%b", i, b3.in_ready, (i < CAP));
            end
            if (b3.in_ready === 1'b1) sent++;
            if (i >= 3) begin
                total++;
                if (b3.out_valid !== 1'b1 || b3.out_data !== 16'h20) begin
                    bad++; $display("FAIL stall_hold i=%0d got=%b/%h want=1/0020", i, b3.out_valid, b3.out_data);
                end
            end
            tick();
        end
        drive3(1'b0, 16'h0, 1'b0, 1'b0);
        #1;
        total++; if (b3.occ !== 3'(CAP)) begin bad++; $display("FAIL stall_occ got=%0d want=%0d", b3.occ, CAP); end
        tick();
        for (int j = 0; j < CAP + 3; j++) begin
            drive3(1'b0, 16'h0, 1'b1, 1'b0);
            #1;
            if (b3.out_valid === 1'b1) begin
                total++;
                if (b3.out_data !== 16'h20 + 16'(rcv)) begin
                    bad++; $display("FAIL stall_drain got=%h want=%h", b3.out_data, 16'h20 + 16'(rcv));
                end
                rcv++;
            end
            tick();
        end
        total++; if (rcv != CAP) begin bad++; $display("FAIL stall_count got=%0d want=%0d", rcv, CAP); end
        total++; if (b3.occ !== 3'd0) begin bad++; $display("FAIL stall_end_occ got=%0d want=0", b3.occ); end
        drive3(1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic test_bubble_collapse();
        drive4(1'b1, 16'h00AA, 1'b0, 1'b0);
        #1;
        total++; if (b4.in_ready !== 1'b1) begin bad++; $display("FAIL bub_in_ready_a got=%b want=1", b4.in_ready); end
        tick();
        drive4(1'b0, 16'h0, 1'b0, 1'b0);
        for (int n = 1; n < 4; n++) begin
            #1;
            total++; if (b4.out_valid !== 1'b0) begin bad++; $display("FAIL bub_early_valid n=%0d got=%b want=0", n, b4.out_valid); end
            tick();
        end
        #1;
        total++; if (b4.out_valid !== 1'b1 || b4.out_data !== 16'h00AA) begin
            bad++; $display("FAIL bub_arrive got=%b/%h want=1/00aa", b4.out_valid, b4.out_data);
        end
        total++; if (b4.occ !== 3'd1) begin bad++; $display("FAIL bub_occ1 got=%0d want=1", b4.occ); end
        drive4(1'b1, 16'h00BB, 1'b0, 1'b0);
        #1;
        total++; if (b4.in_ready !== 1'b1) begin bad++; $display("FAIL bub_in_ready_b got=%b want=1", b4.in_ready); end
        tick();
        drive4(1'b0, 16'h0, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        total++; if (b4.occ !== 3'd2) begin bad++; $display("FAIL bub_occ2 got=%0d want=2", b4.occ); end
        total++; if (b4.out_data !== 16'h00AA) begin bad++; $display("FAIL bub_head got=%h want=00aa", b4.out_data); end
        drive4(1'b0, 16'h0, 1'b1, 1'b0);
        tick();
        total++; if (b4.out_valid !== 1'b1 || b4.out_data !== 16'h00BB) begin
            bad++; $display("FAIL bub_behind got=%b/%h want=1/00bb", b4.out_valid, b4.out_data);
        end
        total++; if (b4.out_ctrl !== ctrl_of(16'h00BB)) begin
            bad++; $display("FAIL bub_ctrl got=%h want=%h", b4.out_ctrl, ctrl_of(16'h00BB));
        end
        tick();
        total++; if (b4.out_valid !== 1'b0 || b4.occ !== 3'd0) begin
            bad++; $display("FAIL bub_empty got=%b/%0d want=0/0", b4.out_valid, b4.occ);
        end
        drive4(1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic test_flush();
        for (int i = 0; i < CAP; i++) begin
            drive3(1'b1, 16'h30 + 16'(i), 1'b0, 1'b0);
            #1;
            total++; if (b3.in_ready !== 1'b1) begin bad++; $display("FAIL flush_fill i=%0d got=%b want=1", i, b3.in_ready); end
            tick();
        end
        drive3(1'b1, 16'h003F, 1'b0, 1'b1);
        #1;
        total++; if (b3.in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%b want=0", b3.in_ready); end
        tick();
        drive3(1'b1, 16'h0040, 1'b1, 1'b0);
        #1;
        total++; if (b3.out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid got=%b want=0", b3.out_valid); end
        total++; if (b3.out_ctrl !== 4'h0) begin bad++; $display("FAIL flush_out_ctrl got=%h want=0", b3.out_ctrl); end
        total++; if (b3.occ !== 3'd0) begin bad++; $display("FAIL flush_occ got=%0d want=0", b3.occ); end
        total++; if (b3.in_ready !== 1'b1) begin bad++; $display("FAIL flush_after_ready got=%b want=1", b3.in_ready); end
        tick();
        drive3(1'b0, 16'h0, 1'b1, 1'b0);
        for (int n = 0; n < 2; n++) begin
            #1;
            total++; if (b3.out_valid !== 1'b0) begin bad++; $display("FAIL flush_lat n=%0d got=%b want=0", n, b3.out_valid); end
            tick();
        end
        total++; if (b3.out_valid !== 1'b1 || b3.out_data !== 16'h0040) begin
            bad++; $display("FAIL flush_first_out got=%b/%h want=1/0040", b3.out_valid, b3.out_data);
        end
        tick();
        total++; if (b3.occ !== 3'd0) begin bad++; $display("FAIL flush_end_occ got=%0d want=0", b3.occ); end
        drive3(1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [15:0] exp_q[$];
        logic        v;
        logic        r;
        logic        f;
        logic [15:0] d;
        for (int c = 0; c < 4000; c++) begin
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) != 0);
            f = ($urandom_range(0, 40) == 0);
            d = 16'($urandom_range(0, 65535));
            drive3(v, d, r, f);
            #1;
            total++; if (b3.occ !== 3'(exp_q.size())) begin bad++; $display("FAIL rand_occ c=%0d got=%0d want=%0d", c, b3.occ, exp_q.size()); end
            if (b3.out_valid === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL rand_spurious c=%0d got=%h want=none", c, b3.out_data);
                end else if (b3.out_data !== exp_q[0] || b3.out_ctrl !== ctrl_of(exp_q[0])) begin
                    bad++; $display("FAIL rand_data c=%0d got=%h/%h want=%h/%h", c, b3.out_data, b3.out_ctrl, exp_q[0], ctrl_of(exp_q[0]));
                end
            end else begin
                total++; if (b3.out_ctrl !== 4'h0) begin bad++; $display("FAIL rand_idle_ctrl c=%0d got=%h want=0", c, b3.out_ctrl); end
            end
            if (f) begin
                total++; if (b3.in_ready !== 1'b0) begin bad++; $display("FAIL rand_flush_ready c=%0d got=%b want=0", c, b3.in_ready); end
            end else if (exp_q.size() == 0) begin
                total++; if (b3.in_ready !== 1'b1) begin bad++; $display("FAIL rand_empty_ready c=%0d got=%b want=1", c, b3.in_ready); end
            end
            if (b3.out_valid === 1'b1 && r && exp_q.size() > 0) void'(exp_q.pop_front());
            if (f) exp_q.delete();
            else if (v && b3.in_ready === 1'b1) exp_q.push_back(d);
            if (bad > 50) break;
            tick();
        end
        drive3(1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    initial begin
        drive3(1'b0, 16'h0, 1'b0, 1'b0);
        drive4(1'b0, 16'h0, 1'b0, 1'b0);
        test_reset();
        test_streaming();
        test_stall();
        test_bubble_collapse();
        test_flush();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
